// File: rtl/rv_warp_fetch_scheduler.sv
// Warp fetch scheduler: keeps per-warp PC/tmask/active/stalled state and issues
// one registered ifetch request per cycle, round-robin over active, unstalled warps.
module rv_warp_fetch_scheduler #(
    parameter int          NUM_WARPS   = 4,
    parameter int          NW_BITS     = 2,
    parameter int          NUM_THREADS = 4,
    parameter int          UUID_BITS   = 16,
    parameter logic [31:0] START_PC    = 32'h80000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   warp_ctl_valid,
    input  logic [NW_BITS-1:0]     warp_ctl_wid,
    input  logic [31:0]            warp_ctl_pc,
    input  logic [NUM_THREADS-1:0] warp_ctl_tmask,
    input  logic                   unlock_valid,
    input  logic [NW_BITS-1:0]     unlock_wid,
    input  logic                   branch_valid,
    input  logic [NW_BITS-1:0]     branch_wid,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_dest,
    output logic                   ifetch_req_if_valid,
    input  logic                   ifetch_req_if_ready,
    output logic [NW_BITS-1:0]     ifetch_req_if_wid,
    output logic [31:0]            ifetch_req_if_PC,
    output logic [NUM_THREADS-1:0] ifetch_req_if_tmask,
    output logic [UUID_BITS-1:0]   ifetch_req_if_uuid,
    output logic [NUM_WARPS-1:0]   active_warps
);

    logic [31:0]            r_pc    [NUM_WARPS];
    logic [NUM_THREADS-1:0] r_tmask [NUM_WARPS];
    logic [NUM_WARPS-1:0]   r_active;
    logic [NUM_WARPS-1:0]   r_stalled;
    logic [NW_BITS-1:0]     r_rr;
    logic [UUID_BITS-1:0]   r_uuid;

    logic                   r_req_valid;
    logic [NW_BITS-1:0]     r_req_wid;
    logic [31:0]            r_req_pc;
    logic [NUM_THREADS-1:0] r_req_tmask;
    logic [UUID_BITS-1:0]   r_req_uuid;

    logic [NUM_WARPS-1:0]   w_eligible;
    logic                   w_found;
    logic [NW_BITS-1:0]     w_pick;
    logic                   w_load;
    logic                   w_sel;

    assign w_eligible = r_active & ~r_stalled;
    assign w_load     = !r_req_valid || ifetch_req_if_ready;
    assign w_sel      = w_load && w_found;

    // Index arithmetic is NW_BITS wide, so the scan wraps modulo NUM_WARPS for free.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        for (int k = 0; k < NUM_WARPS; k++) begin
            if (!w_found && w_eligible[r_rr + NW_BITS'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_rr + NW_BITS'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_pc[w]    <= (w == 0) ? START_PC : 32'h0;
                r_tmask[w] <= (w == 0) ? {NUM_THREADS{1'b1}} : {NUM_THREADS{1'b0}};
            end
            r_active  <= NUM_WARPS'(1);
            r_stalled <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                // Branch redirect only counts for a warp that is actually waiting on it.
                if (warp_ctl_valid && warp_ctl_wid == NW_BITS'(w)) begin
                    r_pc[w]     <= warp_ctl_pc;
                    r_tmask[w]  <= warp_ctl_tmask;
                    r_active[w] <= |warp_ctl_tmask;
                end else if (branch_valid && branch_taken && r_stalled[w]
                             && branch_wid == NW_BITS'(w)) begin
                    r_pc[w] <= branch_dest;
                end else if (w_sel && w_pick == NW_BITS'(w)) begin
                    r_pc[w] <= r_pc[w] + 32'd4;
                end

                if (w_sel && w_pick == NW_BITS'(w)) begin
                    r_stalled[w] <= 1'b1;
                end else if ((unlock_valid && unlock_wid == NW_BITS'(w))
                             || (branch_valid && branch_wid == NW_BITS'(w))) begin
                    r_stalled[w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_wid   <= '0;
            r_req_pc    <= '0;
            r_req_tmask <= '0;
            r_req_uuid  <= '0;
            r_uuid      <= '0;
            r_rr        <= '0;
        end else if (w_load) begin
            r_req_valid <= w_found;
            if (w_found) begin
                r_req_wid   <= w_pick;
                r_req_pc    <= r_pc[w_pick];
                r_req_tmask <= r_tmask[w_pick];
                r_req_uuid  <= r_uuid;
                r_uuid      <= r_uuid + 1'b1;
                r_rr        <= w_pick + 1'b1;
            end
        end
    end

    assign ifetch_req_if_valid = r_req_valid;
    assign ifetch_req_if_wid   = r_req_wid;
    assign ifetch_req_if_PC    = r_req_pc;
    assign ifetch_req_if_tmask = r_req_tmask;
    assign ifetch_req_if_uuid  = r_req_uuid;
    assign active_warps        = r_active;

endmodule
